// File: rtl/egg_timer_ctrl.sv
// Egg timer controller: set minutes/seconds, count down once per second,
// sound an alarm at 00:00 that clears itself after ALARM_SECS seconds.
module egg_timer_ctrl #(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int MAX_MIN       = 59,
    parameter int ALARM_SECS    = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_min_inc,
    input  logic       btn_sec_inc,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       paused,
    output logic       alarm
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] PRE_ONE = PW'(1);
    localparam logic [5:0] MIN_TOP = 6'(MAX_MIN);
    localparam logic [5:0] ASEC_LAST = 6'(ALARM_SECS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_ALARM
    } state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic [5:0]    alarm_cnt;

    logic time_nz;
    logic last_sec;
    assign time_nz  = (minutes != 6'd0) || (seconds != 6'd0);
    assign last_sec = (minutes == 6'd0) && (seconds == 6'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            minutes   <= 6'd0;
            seconds   <= 6'd0;
            prescaler <= '0;
            alarm_cnt <= 6'd0;
            running   <= 1'b0;
            paused    <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (btn_sec_inc)
                        seconds <= (seconds == 6'd59) ? 6'd0 : seconds + 6'd1;
                    if (btn_min_inc)
                        minutes <= (minutes == MIN_TOP) ? 6'd0 : minutes + 6'd1;
                    if (btn_start && !btn_stop && time_nz) begin
                        state     <= S_RUN;
                        prescaler <= '0;
                        running   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (btn_stop) begin
                        state   <= S_PAUSE;
                        running <= 1'b0;
                        paused  <= 1'b1;
                    end else if (prescaler == PRE_MAX) begin
                        prescaler <= '0;
                        if (seconds == 6'd0) begin
                            seconds <= 6'd59;
                            minutes <= minutes - 6'd1;
                        end else begin
                            seconds <= seconds - 6'd1;
                        end
                        if (last_sec) begin
                            state     <= S_ALARM;
                            alarm_cnt <= 6'd0;
                            running   <= 1'b0;
                            alarm     <= 1'b1;
                        end
                    end else begin
                        prescaler <= prescaler + PRE_ONE;
                    end
                end
                S_PAUSE: begin
                    if (btn_stop) begin
                        state     <= S_IDLE;
                        minutes   <= 6'd0;
                        seconds   <= 6'd0;
                        prescaler <= '0;
                        paused    <= 1'b0;
                    end else if (btn_start) begin
                        state   <= S_RUN;
                        paused  <= 1'b0;
                        running <= 1'b1;
                    end
                end
                S_ALARM: begin
                    // Any button acknowledges; otherwise time out on whole seconds
                    if (btn_start || btn_stop) begin
                        state     <= S_IDLE;
                        prescaler <= '0;
                        alarm_cnt <= 6'd0;
                        alarm     <= 1'b0;
                    end else if (prescaler == PRE_MAX) begin
                        prescaler <= '0;
                        if (alarm_cnt == ASEC_LAST) begin
                            state     <= S_IDLE;
                            alarm_cnt <= 6'd0;
                            alarm     <= 1'b0;
                        end else begin
                            alarm_cnt <= alarm_cnt + 6'd1;
                        end
                    end else begin
                        prescaler <= prescaler + PRE_ONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Bench for egg_timer_ctrl: table of single-cycle vectors plus
// directed multi-cycle sequences (run, wraps, expiry, pause, conflicts).
module tb_egg_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_stop = 1'b0;
    logic       btn_min_inc = 1'b0;
    logic       btn_sec_inc = 1'b0;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       running;
    logic       paused;
    logic       alarm;

    int vectors = 0;
    int miscompares = 0;

    egg_timer_ctrl #(
        .TICKS_PER_SEC(4),
        .MAX_MIN(59),
        .ALARM_SECS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_start(btn_start),
        .btn_stop(btn_stop),
        .btn_min_inc(btn_min_inc),
        .btn_sec_inc(btn_sec_inc),
        .minutes(minutes),
        .seconds(seconds),
        .running(running),
        .paused(paused),
        .alarm(alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rst;
        int st;
        int sp;
        int mi;
        int si;
        int m;
        int s;
        int r;
        int p;
        int a;
    } vec_t;

    vec_t tbl[23];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input bit st, input bit sp, input bit mi, input bit si);
        btn_start   = st;
        btn_stop    = sp;
        btn_min_inc = mi;
        btn_sec_inc = si;
        tick();
        btn_start   = 1'b0;
        btn_stop    = 1'b0;
        btn_min_inc = 1'b0;
        btn_sec_inc = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_n(2);
        reset = 1'b1;
    endtask

    task automatic chk(input string name, input int m, input int s,
                       input int r, input int p, input int a);
        vectors++;
        if (int'(minutes) !== m || int'(seconds) !== s ||
            int'(running) !== r || int'(paused) !== p || int'(alarm) !== a) begin
            miscompares++;
            $display("FAIL %s: got %0d:%0d r=%0d p=%0d a=%0d, want %0d:%0d r=%0d p=%0d a=%0d",
                     name, minutes, seconds, running, paused, alarm, m, s, r, p, a);
        end
    endtask

    initial begin
        //          rst st sp mi si   m  s  r  p  a
        tbl[0]  = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 1,   0, 1, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 1,   0, 2, 0, 0, 0};
        tbl[4]  = '{1, 0, 0, 0, 1,   0, 3, 0, 0, 0};
        tbl[5]  = '{1, 0, 0, 1, 0,   1, 3, 0, 0, 0};
        tbl[6]  = '{1, 1, 0, 0, 0,   1, 3, 1, 0, 0};
        tbl[7]  = '{1, 0, 0, 0, 0,   1, 3, 1, 0, 0};
        tbl[8]  = '{1, 0, 0, 0, 0,   1, 3, 1, 0, 0};
        tbl[9]  = '{1, 0, 0, 0, 0,   1, 3, 1, 0, 0};
        tbl[10] = '{1, 0, 0, 0, 0,   1, 2, 1, 0, 0};
        tbl[11] = '{1, 0, 0, 1, 0,   1, 2, 1, 0, 0};
        tbl[12] = '{1, 0, 0, 0, 1,   1, 2, 1, 0, 0};
        tbl[13] = '{1, 1, 1, 0, 0,   1, 2, 0, 1, 0};
        tbl[14] = '{1, 0, 0, 0, 0,   1, 2, 0, 1, 0};
        tbl[15] = '{1, 1, 0, 0, 0,   1, 2, 1, 0, 0};
        tbl[16] = '{1, 0, 0, 0, 0,   1, 2, 1, 0, 0};
        tbl[17] = '{1, 0, 0, 0, 0,   1, 1, 1, 0, 0};
        tbl[18] = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[19] = '{1, 1, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[20] = '{1, 0, 0, 1, 1,   1, 1, 0, 0, 0};
        tbl[21] = '{1, 1, 1, 0, 0,   1, 1, 0, 0, 0};
        tbl[22] = '{0, 1, 0, 1, 0,   0, 0, 0, 0, 0};

        for (int i = 0; i < 23; i++) begin
            reset       = 1'(tbl[i].rst);
            btn_start   = 1'(tbl[i].st);
            btn_stop    = 1'(tbl[i].sp);
            btn_min_inc = 1'(tbl[i].mi);
            btn_sec_inc = 1'(tbl[i].si);
            tick();
            chk($sformatf("tbl%0d", i), tbl[i].m, tbl[i].s,
                tbl[i].r, tbl[i].p, tbl[i].a);
        end
        btn_start   = 1'b0;
        btn_stop    = 1'b0;
        btn_min_inc = 1'b0;
        btn_sec_inc = 1'b0;

        // set 01:03 and run 16 cycles
        do_reset();
        chk("rst", 0, 0, 0, 0, 0);
        repeat (3) press(0, 0, 0, 1);
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        chk("run_start", 1, 3, 1, 0, 0);
        idle_n(4);
        chk("run_4", 1, 2, 1, 0, 0);
        idle_n(12);
        chk("run_16", 0, 59, 1, 0, 0);

        // wraps
        do_reset();
        repeat (59) press(0, 0, 0, 1);
        chk("sec_59", 0, 59, 0, 0, 0);
        press(0, 0, 0, 1);
        chk("sec_wrap", 0, 0, 0, 0, 0);
        repeat (59) press(0, 0, 1, 0);
        chk("min_59", 59, 0, 0, 0, 0);
        press(0, 0, 1, 0);
        chk("min_wrap", 0, 0, 0, 0, 0);
        press(1, 0, 0, 0);
        chk("start_zero", 0, 0, 0, 0, 0);

        // expiry with auto-clear
        do_reset();
        repeat (2) press(0, 0, 0, 1);
        press(1, 0, 0, 0);
        chk("exp_start", 0, 2, 1, 0, 0);
        idle_n(7);
        chk("exp_7", 0, 1, 1, 0, 0);
        idle_n(1);
        chk("exp_alarm", 0, 0, 0, 0, 1);
        idle_n(7);
        chk("exp_alarm_hold", 0, 0, 0, 0, 1);
        idle_n(1);
        chk("exp_autoclr", 0, 0, 0, 0, 0);

        // expiry acknowledged by stop at alarm cycle 3
        repeat (2) press(0, 0, 0, 1);
        press(1, 0, 0, 0);
        idle_n(8);
        chk("ack_alarm", 0, 0, 0, 0, 1);
        idle_n(2);
        press(0, 1, 0, 0);
        chk("ack_stop", 0, 0, 0, 0, 0);

        // acknowledged by start, then a full-length alarm again
        press(0, 0, 0, 1);
        press(1, 0, 0, 0);
        idle_n(4);
        chk("ack2_alarm", 0, 0, 0, 0, 1);
        press(1, 0, 0, 0);
        chk("ack_start", 0, 0, 0, 0, 0);
        press(0, 0, 0, 1);
        press(1, 0, 0, 0);
        idle_n(4);
        idle_n(7);
        chk("alarm_full_7", 0, 0, 0, 0, 1);
        idle_n(1);
        chk("alarm_full_8", 0, 0, 0, 0, 0);

        // pause keeps prescaler and time
        do_reset();
        repeat (6) press(0, 0, 0, 1);
        press(1, 0, 0, 0);
        idle_n(4);
        chk("pause_pre0", 0, 5, 1, 0, 0);
        idle_n(2);
        press(0, 1, 0, 0);
        chk("pause_enter", 0, 5, 0, 1, 0);
        idle_n(20);
        chk("pause_frozen", 0, 5, 0, 1, 0);
        press(1, 0, 0, 0);
        chk("resume", 0, 5, 1, 0, 0);
        idle_n(1);
        chk("resume_1", 0, 5, 1, 0, 0);
        idle_n(1);
        chk("resume_2", 0, 4, 1, 0, 0);
        press(0, 1, 0, 0);
        chk("pause2", 0, 4, 0, 1, 0);
        press(0, 1, 0, 0);
        chk("pause_clear", 0, 0, 0, 0, 0);

        // conflicts and reset mid-run
        do_reset();
        repeat (30) press(0, 0, 0, 1);
        press(1, 0, 0, 0);
        chk("c_run", 0, 30, 1, 0, 0);
        press(1, 1, 0, 0);
        chk("c_both_run", 0, 30, 0, 1, 0);
        press(1, 0, 0, 0);
        idle_n(1);
        chk("c_rerun", 0, 30, 1, 0, 0);
        reset = 1'b0;
        tick();
        chk("c_reset_run", 0, 0, 0, 0, 0);
        reset = 1'b1;
        press(1, 0, 0, 0);
        chk("c_after_reset", 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/egg_timer_ctrl.md
EGG_TIMER_CTRL -- requirements
Module: egg_timer_ctrl

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100000000, clk cycles per timer second (legal 2..2^27).
REQ-002 SHALL have parameter MAX_MIN, default 59, highest settable minutes value (legal 1..63).
REQ-003 SHALL have parameter ALARM_SECS, default 10, seconds the alarm sounds before auto-clear (legal 1..63).
REQ-004 SHALL have port: clk  input  1  system clock; all logic on posedge.
REQ-005 SHALL have port: reset  input  1  one clock; reset is synchronous and active-low.
REQ-006 SHALL have port: btn_start  input  1  one-cycle pulse: start or resume.
REQ-007 SHALL have port: btn_stop  input  1  one-cycle pulse: pause, clear or acknowledge.
REQ-008 SHALL have port: btn_min_inc  input  1  one-cycle pulse: minutes +1 while setting.
REQ-009 SHALL have port: btn_sec_inc  input  1  one-cycle pulse: seconds +1 while setting.
REQ-010 SHALL have port: minutes  output  6  current minutes, binary.
REQ-011 SHALL have port: seconds  output  6  current seconds, binary 0..59.
REQ-012 SHALL have port: running  output  1  high when state is RUN.
REQ-013 SHALL have port: paused  output  1  high when state is PAUSE.
REQ-014 SHALL have port: alarm  output  1  high when state is ALARM.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, PAUSE, ALARM; running/paused/alarm are decoded from the state register only, so each is valid the cycle after the transition edge.
REQ-016 SHALL, in IDLE, apply btn_sec_inc as seconds+1 with 59 wrapping to 0, no carry into minutes.
REQ-017 SHALL, in IDLE, apply btn_min_inc as minutes+1 with MAX_MIN wrapping to 0.
REQ-018 SHALL apply btn_sec_inc and btn_min_inc together when both are high in the same IDLE cycle.
REQ-019 SHALL ignore btn_min_inc and btn_sec_inc in RUN, PAUSE and ALARM.
REQ-020 SHALL, in IDLE, move to RUN on btn_start only when the time is nonzero, clearing the prescaler to 0; btn_start at 00:00 is ignored.
REQ-021 SHALL, in RUN, increment the prescaler every cycle; when it equals TICKS_PER_SEC-1 it wraps to 0 and the time decrements by one second at that same edge.
REQ-022 SHALL decrement the time as follows: seconds>0 -> seconds-1; seconds=0 -> seconds=59 and minutes-1.
REQ-023 SHALL enter ALARM on the edge where a decrement yields 00:00, and clear the prescaler to 0.
REQ-024 SHALL, in RUN, move to PAUSE on btn_stop, holding both the prescaler and the time.
REQ-025 SHALL, in PAUSE, move to RUN on btn_start, resuming from the held prescaler value.
REQ-026 SHALL, in PAUSE, move to IDLE on btn_stop and clear the time to 00:00.
REQ-027 SHALL, in ALARM, count whole seconds with the prescaler; after ALARM_SECS seconds it moves to IDLE.
REQ-028 SHALL, in ALARM, move to IDLE on btn_start or btn_stop at the next edge; the time remains 00:00.
REQ-029 SHALL let btn_stop win over btn_start when both are high in the same cycle: RUN->PAUSE, PAUSE->IDLE, IDLE no change, ALARM->IDLE.
REQ-030 SHALL size the prescaler at $clog2(TICKS_PER_SEC) bits; the alarm seconds counter is 6 bits; no arithmetic overflows within the legal parameter ranges.

Reset
REQ-031 SHALL, on any posedge clk with reset=0, set state IDLE, minutes=0, seconds=0, prescaler=0, alarm counter=0, running=0, paused=0, alarm=0, regardless of state or buttons.
REQ-032 SHALL ignore all buttons during the cycle in which reset=0; normal operation resumes on the first edge with reset=1.

Verification (TICKS_PER_SEC=4, MAX_MIN=59, ALARM_SECS=2)
REQ-033 SHALL cover reset: reset=0 for 2 cycles from any state -> outputs 00:00, running=paused=alarm=0.
REQ-034 SHALL cover set/run: 3 sec_inc, 1 min_inc, then start -> 01:03, running=1; 4 cycles later 01:02; 16 cycles after start 00:59.
REQ-035 SHALL cover wraps: 60 sec_inc from 00:00 -> 00:00; 60 min_inc from 00:00 -> 00:00; start at 00:00 -> state stays IDLE.
REQ-036 SHALL cover expiry: 00:02 then start -> alarm=1, running=0 at 8 cycles; alarm=0, IDLE 8 cycles later; repeat with stop at alarm cycle 3 -> IDLE next edge.
REQ-037 SHALL cover pause: at 00:05 with prescaler=2, stop -> paused=1, time frozen 20 cycles; start -> 00:04 after 2 cycles; stop, stop -> IDLE, 00:00.
REQ-038 SHALL cover conflicts: start+stop together in RUN -> PAUSE; reset=0 mid-RUN at 00:30 -> next edge IDLE, 00:00.
